pipeline_controller: RTL and testbench
======================================

# pipeline_controller

Sequencing controller for the 4-bit-opcode, five-stage (F/D/E/M/W) CPU datapath. Decodes the opcode presented by the decode stage into per-instruction control signals and drives the pipeline's `enable` and `flushC`. Owns run/stop sequencing: start from idle, one-cycle branch-shadow bubble, load-use interlock, and drain-to-halt. Sits beside the datapath at CPU top level; every datapath control input comes from this block.

## Interface
- `LOAD_STALL`, default 2: bubble cycles inserted after a load (legal range 1..7).
- `DRAIN_CYCLES`, default 3: cycles spent retiring E/M/W after HALT (legal range 1..7).

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle pulse; leaves IDLE or HALTED
- `opcodeDP`  in  4  opcode of the instruction in decode
- `enable`  out  1  advances PC and decode register
- `flushC`  out  1  inserts a bubble into the execute register
- `branchC`  out  1  selects the branch target as next PC
- `RegWriteC`, `MemWriteC`, `MemToRegC`, `immediateC`  out  1 each  instruction controls
- `alufuncC`  out  2  ALU operation: 00 add, 01 sub, 10 and, 11 or
- `busy`  out  1  high in RUN, BR_SHADOW, LD_STALL, DRAIN
- `halted`  out  1  high in HALTED
- `illegal`  out  1  registered sticky flag for an undefined opcode, cleared by reset or `start`

## Operation
- Opcode map:
  - 0000 NOP: no controls.
  - 0001 ADD, 0010 SUB, 0011 AND, 0100 OR: RegWrite, alufunc 00/01/10/11.
  - 0101 ADDI: RegWrite, immediate, alufunc 00.
  - 0110 LD: RegWrite, MemToReg, immediate, alufunc 00.
  - 0111 ST: MemWrite, immediate, alufunc 00.
  - 1000 BR: branchC.
  - 1111 HALT.
  - All other codes: treated as NOP and set `illegal`.
- Instruction controls and `branchC` are a combinational decode of `opcodeDP`. They are forced to 0 unless the state is RUN.
- FSM states: IDLE, RUN, BR_SHADOW, LD_STALL, DRAIN, HALTED.
  - IDLE: `enable`=0, `flushC`=1. `start` moves to RUN.
  - RUN: `enable`=1, `flushC`=0.
    - BR moves to BR_SHADOW.
    - LD loads the counter with `LOAD_STALL` and moves to LD_STALL.
    - HALT loads the counter with `DRAIN_CYCLES`, moves to DRAIN, and drives `enable`=0 and `flushC`=1 in that same cycle.
  - BR_SHADOW: one cycle, `enable`=1, `flushC`=1. This discards the wrong-path instruction fetched behind the branch. Returns to RUN.
  - LD_STALL: `enable`=0, `flushC`=1. The counter decrements each cycle; at counter==1 the next state is RUN.
  - DRAIN: `enable`=0, `flushC`=1. The counter decrements; at counter==1 the next state is HALTED.
  - HALTED: `enable`=0, `flushC`=1. `start` moves to RUN; the pipeline resumes at the held PC.
- Counter width is 3 bits and the counter never wraps. A parameter value of 0 is illegal and is flagged by an elaboration assertion.
- Only LD is interlocked. ALU read-after-write hazards are the software's responsibility (NOP padding).

## Timing
- Reset values: state IDLE, counter 0, `illegal` 0. Outputs during reset: `enable`=0, `flushC`=1, `branchC`=0, all instruction controls 0, `busy`=0, `halted`=0.
- Decode latency is 0 cycles: controls are valid in the same cycle `opcodeDP` is valid. State and counter update on the `clk` edge.
- LD in D at cycle t:
  - Cycles t+1 .. t+LOAD_STALL: stall.
  - Cycle t+LOAD_STALL+1: the following instruction issues.
- BR in D at cycle t: `branchC`=1 at t; bubble at t+1; the target instruction is in D at t+2.
- HALT in D at cycle t: `enable`=0 from t onward; `halted`=1 at t+DRAIN_CYCLES+1.
- `start` outside IDLE/HALTED is ignored. `start` coincident with `reset`: reset wins.
- Opcodes in D during BR_SHADOW, LD_STALL or DRAIN are not decoded. This includes HALT and BR in a branch shadow.
- Reset mid-operation, including mid-stall or mid-drain, returns to IDLE on the next edge. There is no partial drain.

## Structure
- Package `cpu_ctrl_pkg`:
  - opcode constants (OP_NOP … OP_HALT)
  - ALU function encodings
  - FSM state enum
  - control-bundle struct {regwrite, memwrite, memtoreg, immediate, branch, alufunc}
- Sub-module `opcode_decoder`: pure combinational `opcodeDP` → control bundle plus an illegal bit.
- The FSM, counter and output gating live in `pipeline_controller`.

## Test plan
- Reset, then `start`, then ADD (0001) in D → same cycle: RegWriteC=1, alufuncC=00, `enable`=1, `flushC`=0, `busy`=1.
- LD (0110) at cycle t with LOAD_STALL=2 → `enable`=0 and `flushC`=1 at t+1 and t+2; `enable`=1 at t+3; RegWriteC=MemToRegC=immediateC=1 at t.
- BR (1000) at t → `branchC`=1 at t; `flushC`=1 with `enable`=1 at t+1; HALT placed in the shadow is ignored; RUN at t+2.
- HALT (1111) at t, DRAIN_CYCLES=3 → `enable`=0 from t; `halted`=1 at t+4; `start` at t+6 → RUN at t+7.
- Opcode 1010 → all controls 0, `illegal`=1 from the next cycle; the flag persists until `start` or `reset`.
- `reset` asserted during the second LD_STALL cycle → next cycle IDLE with `enable`=0, `flushC`=1, `busy`=0; `start` is required to resume.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the five-stage CPU control path: opcode constants,
// ALU function encodings, the sequencing FSM state type and the per-instruction
// control bundle produced by opcode_decoder.
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_ADDI = 4'b0101;
   localparam logic [3:0] OP_LD   = 4'b0110;
   localparam logic [3:0] OP_ST   = 4'b0111;
   localparam logic [3:0] OP_BR   = 4'b1000;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_BR_SHADOW,
      ST_LD_STALL,
      ST_DRAIN,
      ST_HALTED
   } state_e;

   typedef struct packed {
      logic       regwrite;
      logic       memwrite;
      logic       memtoreg;
      logic       immediate;
      logic       branch;
      logic [1:0] alufunc;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/opcode_decoder.sv
// -----------------------------------------------------------------------------
// opcode_decoder
// Pure combinational decode of the 4-bit opcode in the decode stage.
//   opcode_i   in  4  opcode of the instruction in decode
//   ctrl_o     out    control bundle (regwrite/memwrite/memtoreg/immediate/
//                     branch/alufunc)
//   illegal_o  out 1  opcode is not in the instruction map (decoded as NOP)
// -----------------------------------------------------------------------------
module opcode_decoder
   import cpu_ctrl_pkg::*;
(
   input  logic [3:0] opcode_i,
   output ctrl_t      ctrl_o,
   output logic       illegal_o
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      ctrl_o    = CTRL_NONE;
      illegal_o = 1'b0;
      unique case (opcode_i)
         OP_NOP, OP_HALT: ;
         OP_ADD:  begin ctrl_o.regwrite = 1'b1; ctrl_o.alufunc = ALU_ADD; end
         OP_SUB:  begin ctrl_o.regwrite = 1'b1; ctrl_o.alufunc = ALU_SUB; end
         OP_AND:  begin ctrl_o.regwrite = 1'b1; ctrl_o.alufunc = ALU_AND; end
         OP_OR:   begin ctrl_o.regwrite = 1'b1; ctrl_o.alufunc = ALU_OR;  end
         OP_ADDI: begin
            ctrl_o.regwrite  = 1'b1;
            ctrl_o.immediate = 1'b1;
         end
         OP_LD: begin
            ctrl_o.regwrite  = 1'b1;
            ctrl_o.memtoreg  = 1'b1;
            ctrl_o.immediate = 1'b1;
         end
         OP_ST: begin
            ctrl_o.memwrite  = 1'b1;
            ctrl_o.immediate = 1'b1;
         end
         OP_BR:   ctrl_o.branch = 1'b1;
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/pipeline_controller.sv
// -----------------------------------------------------------------------------
// pipeline_controller
// Run/stop sequencer and control decode for the F/D/E/M/W datapath.
//   clk, reset          clock; synchronous active-high reset
//   start               pulse: leave IDLE or HALTED
//   opcodeDP [3:0]      opcode of the instruction in decode
//   enable              advance PC and decode register
//   flushC              insert a bubble into the execute register
//   branchC             select branch target as next PC
//   RegWriteC, MemWriteC, MemToRegC, immediateC, alufuncC[1:0]
//                       instruction controls (zero outside RUN)
//   busy, halted        run-state indicators
//   illegal             sticky undefined-opcode flag
// Parameters: LOAD_STALL (1..7) bubbles after a load, DRAIN_CYCLES (1..7)
// cycles retiring E/M/W after HALT.
// -----------------------------------------------------------------------------
module pipeline_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned LOAD_STALL   = 2,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] opcodeDP,
   output logic       enable,
   output logic       flushC,
   output logic       branchC,
   output logic       RegWriteC,
   output logic       MemWriteC,
   output logic       MemToRegC,
   output logic       immediateC,
   output logic [1:0] alufuncC,
   output logic       busy,
   output logic       halted,
   output logic       illegal
);

   if (LOAD_STALL < 1 || LOAD_STALL > 7) begin : g_bad_load_stall
      $error("pipeline_controller: LOAD_STALL must be in 1..7");
   end
   if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 7) begin : g_bad_drain_cycles
      $error("pipeline_controller: DRAIN_CYCLES must be in 1..7");
   end

   ctrl_t      dec_ctrl;
   logic       dec_illegal;
   state_e     state_q;
   logic [2:0] cnt_q;
   logic       illegal_q;

   opcode_decoder u_decoder (
      .opcode_i  (opcodeDP),
      .ctrl_o    (dec_ctrl),
      .illegal_o (dec_illegal)
   );

   // Sequencing FSM with its stall/drain counter and the sticky illegal flag.
   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 3'd0;
         illegal_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_HALTED: begin
               if (start) begin
                  state_q   <= ST_RUN;
                  illegal_q <= 1'b0;
               end
            end
            ST_RUN: begin
               illegal_q <= illegal_q | dec_illegal;
               if (opcodeDP == OP_BR) begin
                  state_q <= ST_BR_SHADOW;
               end else if (opcodeDP == OP_LD) begin
                  state_q <= ST_LD_STALL;
                  cnt_q   <= 3'(LOAD_STALL);
               end else if (opcodeDP == OP_HALT) begin
                  state_q <= ST_DRAIN;
                  cnt_q   <= 3'(DRAIN_CYCLES);
               end
            end
            ST_BR_SHADOW: state_q <= ST_RUN;
            ST_LD_STALL, ST_DRAIN: begin
               // Saturating decrement: the counter never wraps below zero.
               if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
               if (cnt_q <= 3'd1) state_q <= (state_q == ST_DRAIN) ? ST_HALTED : ST_RUN;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Outputs are forced to their idle values while reset is held, so the
   // datapath sees a bubble even before the synchronous reset edge lands.
   logic  in_run;
   logic  issuing;
   ctrl_t ctrl_g;

   assign in_run  = (state_q == ST_RUN) && !reset;
   // HALT in D stops issue in the same cycle it is decoded.
   assign issuing = in_run && (opcodeDP != OP_HALT);
   assign ctrl_g  = in_run ? dec_ctrl : CTRL_NONE;

   assign enable  = issuing || ((state_q == ST_BR_SHADOW) && !reset);
   assign flushC  = !issuing;
   assign busy    = !reset && (state_q inside {ST_RUN, ST_BR_SHADOW, ST_LD_STALL, ST_DRAIN});
   assign halted  = !reset && (state_q == ST_HALTED);
   assign illegal = illegal_q;

   assign branchC    = ctrl_g.branch;
   assign RegWriteC  = ctrl_g.regwrite;
   assign MemWriteC  = ctrl_g.memwrite;
   assign MemToRegC  = ctrl_g.memtoreg;
   assign immediateC = ctrl_g.immediate;
   assign alufuncC   = ctrl_g.alufunc;

endmodule

// File: tb/tb_pipeline_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_controller
// Directed vector table for the documented scenarios, then randomized stimulus
// against a timestamp-based reference model.
// Observed vector bit order:
//   {enable, flushC, branchC, RegWriteC, MemWriteC, MemToRegC, immediateC,
//    alufuncC[1:0], busy, halted, illegal}
// -----------------------------------------------------------------------------
module tb_pipeline_controller;

   localparam int L = 2;
   localparam int D = 3;

   logic       clk = 1'b0;
   logic       reset, start;
   logic [3:0] opcodeDP;
   logic       enable, flushC, branchC, RegWriteC, MemWriteC, MemToRegC, immediateC;
   logic [1:0] alufuncC;
   logic       busy, halted, illegal;
   logic [11:0] got;

   int errors = 0;
   int checks = 0;

   pipeline_controller #(.LOAD_STALL(L), .DRAIN_CYCLES(D)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .opcodeDP   (opcodeDP),
      .enable     (enable),
      .flushC     (flushC),
      .branchC    (branchC),
      .RegWriteC  (RegWriteC),
      .MemWriteC  (MemWriteC),
      .MemToRegC  (MemToRegC),
      .immediateC (immediateC),
      .alufuncC   (alufuncC),
      .busy       (busy),
      .halted     (halted),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   assign got = {enable, flushC, branchC, RegWriteC, MemWriteC, MemToRegC,
                 immediateC, alufuncC, busy, halted, illegal};

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Drive inputs just after a rising edge, compare on the falling edge,
   // then advance to the next rising edge.
   task automatic cycle(input logic r, input logic s, input logic [3:0] op,
                        input logic [11:0] exp, input string name);
      reset = r; start = s; opcodeDP = op;
      @(negedge clk);
      check(name, got, exp);
      @(posedge clk); #1;
   endtask

   // ---------------- Reference model ----------------
   // Instruction-map controls {branch, regwrite, memwrite, memtoreg, immediate, alufunc}.
   function automatic logic [6:0] ref_ctrl(input logic [3:0] op);
      case (op)
         4'd1:    return 7'b0100000;
         4'd2:    return 7'b0100001;
         4'd3:    return 7'b0100010;
         4'd4:    return 7'b0100011;
         4'd5:    return 7'b0100100;
         4'd6:    return 7'b0101100;
         4'd7:    return 7'b0010100;
         4'd8:    return 7'b1000000;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic bit ref_illegal(input logic [3:0] op);
      return (op >= 4'd9) && (op <= 4'd14);
   endfunction

   // The model tracks the cycle number and the last cycle of the current
   // shadow/stall/drain window rather than an explicit state machine.
   int  m_cycle     = 0;
   bit  m_started   = 0;  // RUN or inside a stall/shadow/drain window
   bit  m_halted    = 0;
   int  m_block_end = -1;
   bit  m_drain     = 0;  // current window ends in HALTED
   bit  m_branch    = 0;  // current window is a branch shadow
   bit  m_ill       = 0;

   function automatic logic [11:0] model_out(input bit r, input logic [3:0] op);
      logic [6:0] c;
      if (r)                       return {2'b01, 7'b0, 2'b00, m_ill};
      if (!m_started)              return {2'b01, 7'b0, 1'b0, m_halted, m_ill};
      if (m_cycle <= m_block_end)  return {m_branch, 1'b1, 7'b0, 2'b10, m_ill};
      c = ref_ctrl(op);
      return {op != 4'hF, op == 4'hF, c, 2'b10, m_ill};
   endfunction

   task automatic model_step(input bit r, input bit s, input logic [3:0] op);
      if (r) begin
         m_started = 0; m_halted = 0; m_block_end = -1; m_ill = 0;
      end else if (!m_started) begin
         if (s) begin m_started = 1; m_halted = 0; m_ill = 0; end
      end else if (m_cycle <= m_block_end) begin
         if (m_cycle == m_block_end && m_drain) begin m_started = 0; m_halted = 1; end
      end else begin
         m_ill = m_ill | ref_illegal(op);
         m_drain = 0; m_branch = 0;
         if (op == 4'd8)      begin m_block_end = m_cycle + 1; m_branch = 1; end
         else if (op == 4'd6) m_block_end = m_cycle + L;
         else if (op == 4'hF) begin m_block_end = m_cycle + D; m_drain = 1; end
      end
      m_cycle++;
   endtask

   // ---------------- Directed vectors ----------------
   typedef struct {
      logic        r;
      logic        s;
      logic [3:0]  op;
      logic [11:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   initial begin
      reset = 1'b1; start = 1'b0; opcodeDP = 4'd0;
      @(posedge clk); #1;

      vecs = '{
         '{1, 0, 4'h0, 12'b010000000000, "reset_state"},
         '{0, 1, 4'h1, 12'b010000000000, "idle_start"},
         '{0, 0, 4'h1, 12'b100100000100, "run_add"},
         '{0, 0, 4'h2, 12'b100100001100, "run_sub"},
         '{0, 0, 4'h6, 12'b100101100100, "ld_issue"},
         '{0, 0, 4'h1, 12'b010000000100, "ld_stall1"},
         '{0, 0, 4'h1, 12'b010000000100, "ld_stall2"},
         '{0, 0, 4'h1, 12'b100100000100, "ld_resume"},
         '{0, 0, 4'h7, 12'b100010100100, "run_st"},
         '{0, 0, 4'h8, 12'b101000000100, "br_issue"},
         '{0, 0, 4'hF, 12'b110000000100, "br_shadow_halt_ignored"},
         '{0, 0, 4'h4, 12'b100100011100, "br_target_or"},
         '{0, 0, 4'hA, 12'b100000000100, "illegal_op"},
         '{0, 0, 4'h3, 12'b100100010101, "illegal_sticky_and"},
         '{0, 0, 4'hF, 12'b010000000101, "halt_issue"},
         '{0, 0, 4'h0, 12'b010000000101, "drain1"},
         '{0, 0, 4'h0, 12'b010000000101, "drain2"},
         '{0, 0, 4'h0, 12'b010000000101, "drain3"},
         '{0, 0, 4'h0, 12'b010000000011, "halted_t4"},
         '{0, 0, 4'h0, 12'b010000000011, "halted_t5"},
         '{0, 1, 4'h0, 12'b010000000011, "halted_start_t6"},
         '{0, 0, 4'h5, 12'b100100100100, "resume_addi_t7"},
         '{0, 0, 4'h6, 12'b100101100100, "ld2_issue"},
         '{0, 1, 4'h1, 12'b010000000100, "ld2_stall1_start_ignored"},
         '{1, 0, 4'h1, 12'b010000000000, "reset_mid_stall"},
         '{0, 0, 4'h1, 12'b010000000000, "after_reset_idle"},
         '{0, 0, 4'h1, 12'b010000000000, "idle_no_start"},
         '{1, 1, 4'h1, 12'b010000000000, "reset_beats_start"},
         '{0, 0, 4'h1, 12'b010000000000, "still_idle"},
         '{0, 1, 4'h1, 12'b010000000000, "restart"},
         '{0, 0, 4'h2, 12'b100100001100, "rerun_sub"}
      };

      foreach (vecs[i]) cycle(vecs[i].r, vecs[i].s, vecs[i].op, vecs[i].exp, vecs[i].name);

      // ---------------- Randomized run against the model ----------------
      for (int i = 0; i < 3000; i++) begin
         bit r, s;
         logic [3:0] op;
         r  = (i == 0) || ($urandom_range(0, 49) == 0);
         // Start during RUN with the illegal flag set is left out: whether it
         // clears the flag there is not a defined behaviour.
         s  = ($urandom_range(0, 3) == 0) && (!m_started || !m_ill);
         op = 4'($urandom_range(0, 15));
         cycle(r, s, op, model_out(r, op), "random");
         model_step(r, s, op);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
